addsub_seq: RTL and testbench

ADDSUB_SEQ -- requirements
Module: addsub_seq

---
 rtl/addsub_seq.sv | 143 ++++++++++++++
 tb/tb_addsub_seq.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/addsub_seq.sv
// addsub_seq -- chunk-serial adder/subtractor.
//
// Adds or subtracts two inSize-bit operands, chunk bits per enabled clock,
// over N = inSize/chunk cycles. A new result is published on sum/ovf, and
// valid is asserted, only when the last chunk has been processed. sum/ovf
// keep that result until the next operation completes.
//
// Optional feature: define ADDSUB_SAT_EN to saturate sum[inSize-1:0] to the
// signed max/min on overflow. The default build wraps.
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-low reset
//   en     in   clock enable; 0 freezes every register
//   start  in   request a new operation (accepted in IDLE or DONE only)
//   mode   in   0 = A+B, 1 = A-B
//   A, B   in   operands, inSize bits
//   sum    out  result; sum[inSize] = carry (add) or borrow (sub)
//   ovf    out  signed overflow
//   busy   out  high while chunks are being processed
//   valid  out  high for the DONE state
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | waiting for start
// RUN   | one chunk added per enabled edge
// DONE  | result published, valid=1, start may re-launch
module addsub_seq #(
  parameter int inSize = 8,
  parameter int chunk  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              start,
  input  logic              mode,
  input  logic [inSize-1:0] A,
  input  logic [inSize-1:0] B,
  output logic [inSize:0]   sum,
  output logic              ovf,
  output logic              busy,
  output logic              valid
);

  localparam int N     = inSize / chunk;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_carry;
  logic              r_mode;
  logic              r_a_sign;
  logic              r_b_sign;
  logic [inSize-1:0] r_a;
  logic [inSize-1:0] r_b;
  logic [inSize-1:0] r_acc;
  logic [inSize:0]   r_sum;
  logic              r_ovf;

  logic [chunk:0]    w_slice;
  logic [inSize-1:0] w_acc_nxt;
  logic [inSize-1:0] w_res;
  logic              w_msb;
  logic              w_ovf;

  // Operands are shifted right each cycle, so the active chunk always sits
  // in the low bits and no variable part-select is needed.
  assign w_slice = (chunk+1)'(r_a[chunk-1:0]) + (chunk+1)'(r_b[chunk-1:0])
                 + (chunk+1)'(r_carry);

  // Result slices enter from the top; after N shifts the word is aligned.
  assign w_acc_nxt = (r_acc >> chunk)
                   | (inSize'(w_slice[chunk-1:0]) << (inSize - chunk));

  // For subtraction the carry-out is inverted to give the borrow.
  assign w_msb = w_slice[chunk] ^ r_mode;
  assign w_ovf = (r_a_sign == r_b_sign) && (w_acc_nxt[inSize-1] != r_a_sign);

`ifdef ADDSUB_SAT_EN
  assign w_res = w_ovf ? (r_a_sign ? {1'b1, {(inSize-1){1'b0}}}
                                   : {1'b0, {(inSize-1){1'b1}}})
                       : w_acc_nxt;
`else
  assign w_res = w_acc_nxt;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_mode   <= 1'b0;
      r_a_sign <= 1'b0;
      r_b_sign <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_sum    <= '0;
      r_ovf    <= 1'b0;
    end else if (en) begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state  <= S_RUN;
            r_cnt    <= CNT_W'(N - 1);
            r_mode   <= mode;
            r_carry  <= mode;
            r_a      <= A;
            r_b      <= mode ? ~B : B;
            r_a_sign <= A[inSize-1];
            r_b_sign <= B[inSize-1] ^ mode;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_a     <= r_a >> chunk;
          r_b     <= r_b >> chunk;
          r_carry <= w_slice[chunk];
          r_acc   <= w_acc_nxt;
          if (r_cnt == '0) begin
            r_state <= S_DONE;
            r_sum   <= {w_msb, w_res};
            r_ovf   <= w_ovf;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sum   = r_sum;
  assign ovf   = r_ovf;
  assign busy  = (r_state == S_RUN);
  assign valid = (r_state == S_DONE);

endmodule

// File: tb/tb_addsub_seq.sv
// tb_addsub_seq -- directed self-checking bench for addsub_seq (inSize=8,
// chunk=2, so four processing cycles per operation).
module tb_addsub_seq;

  logic       clk;
  logic       rst;
  logic       en;
  logic       start;
  logic       mode;
  logic [7:0] A;
  logic [7:0] B;
  logic [8:0] sum;
  logic       ovf;
  logic       busy;
  logic       valid;

  int n_total = 0;
  int n_bad   = 0;

  logic [8:0] last_sum;
  logic       last_ovf;

  addsub_seq #(.inSize(8), .chunk(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .start (start),
    .mode  (mode),
    .A     (A),
    .B     (B),
    .sum   (sum),
    .ovf   (ovf),
    .busy  (busy),
    .valid (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT in IDLE, en=1 and start=0.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic m, input logic [8:0] exp_sum, input logic exp_ovf);
    A = a; B = b; mode = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, ".busy_c1"}, 16'(busy), 16'd1);
    chk({tag, ".valid_c1"}, 16'(valid), 16'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk({tag, ".busy_run"}, 16'(busy), 16'd1);
      chk({tag, ".sum_hold"}, 16'(sum), 16'(last_sum));
    end
    @(negedge clk);
    chk({tag, ".valid"}, 16'(valid), 16'd1);
    chk({tag, ".busy_done"}, 16'(busy), 16'd0);
    chk({tag, ".sum"}, 16'(sum), 16'(exp_sum));
    chk({tag, ".ovf"}, 16'(ovf), 16'(exp_ovf));
    last_sum = exp_sum;
    last_ovf = exp_ovf;
    @(negedge clk);
    chk({tag, ".valid_drop"}, 16'(valid), 16'd0);
    chk({tag, ".sum_keep"}, 16'(sum), 16'(last_sum));
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; start = 1'b0; mode = 1'b0; A = '0; B = '0;
    last_sum = '0; last_ovf = 1'b0;
    #1 rst = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst.sum", 16'(sum), 16'd0);
    chk("rst.ovf", 16'(ovf), 16'd0);
    chk("rst.busy", 16'(busy), 16'd0);
    chk("rst.valid", 16'(valid), 16'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle.valid", 16'(valid), 16'd0);

    // basic arithmetic
    run_op("add_1_2",   8'h01, 8'h02, 1'b0, 9'h003, 1'b0);
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 9'h100, 1'b0);
    run_op("sub_3_5",   8'h03, 8'h05, 1'b1, 9'h1FE, 1'b0);
`ifdef ADDSUB_SAT_EN
    run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 9'h07F, 1'b1);
    run_op("sub_80_01", 8'h80, 8'h01, 1'b1, 9'h080, 1'b1);
`else
    run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 9'h080, 1'b1);
    run_op("sub_80_01", 8'h80, 8'h01, 1'b1, 9'h07F, 1'b1);
`endif
    run_op("sub_0a_03", 8'h0A, 8'h03, 1'b1, 9'h007, 1'b0);

    // en=0 stall mid-RUN, start held (and inputs changed) during RUN
    A = 8'h12; B = 8'h34; mode = 1'b0; start = 1'b1;
    @(negedge clk);
    A = 8'hFF; B = 8'hFF; mode = 1'b1;
    chk("stall.busy0", 16'(busy), 16'd1);
    @(negedge clk);
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall.busy_frozen", 16'(busy), 16'd1);
      chk("stall.valid_frozen", 16'(valid), 16'd0);
    end
    en = 1'b1;
    @(negedge clk);
    chk("stall.valid_c6", 16'(valid), 16'd0);
    @(negedge clk);
    chk("stall.valid_c7", 16'(valid), 16'd0);
    start = 1'b0;
    @(negedge clk);
    chk("stall.valid", 16'(valid), 16'd1);
    chk("stall.sum", 16'(sum), 16'h046);
    chk("stall.ovf", 16'(ovf), 16'd0);
    last_sum = 9'h046; last_ovf = 1'b0;
    en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("stall.valid_hold", 16'(valid), 16'd1);
      chk("stall.sum_hold", 16'(sum), 16'h046);
    end
    en = 1'b1;
    @(negedge clk);
    chk("stall.valid_exit", 16'(valid), 16'd0);

    // asynchronous reset mid-RUN
    A = 8'h01; B = 8'h01; mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst.sum", 16'(sum), 16'd0);
    chk("arst.ovf", 16'(ovf), 16'd0);
    chk("arst.busy", 16'(busy), 16'd0);
    chk("arst.valid", 16'(valid), 16'd0);
    @(negedge clk);
    rst = 1'b1;
    last_sum = '0; last_ovf = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("arst.no_valid", 16'(valid), 16'd0);
      chk("arst.no_busy", 16'(busy), 16'd0);
    end

    // back-to-back: start held into DONE relaunches immediately
    A = 8'h01; B = 8'h02; mode = 1'b0; start = 1'b1;
    @(negedge clk);
    A = 8'h0A; B = 8'h03; mode = 1'b1;
    for (int k = 0; k < 3; k++) @(negedge clk);
    @(negedge clk);
    chk("b2b.valid1", 16'(valid), 16'd1);
    chk("b2b.sum1", 16'(sum), 16'h003);
    @(negedge clk);
    start = 1'b0;
    chk("b2b.valid_one_cycle", 16'(valid), 16'd0);
    chk("b2b.busy_again", 16'(busy), 16'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("b2b.sum_hold", 16'(sum), 16'h003);
    end
    @(negedge clk);
    chk("b2b.valid2", 16'(valid), 16'd1);
    chk("b2b.sum2", 16'(sum), 16'h007);
    chk("b2b.ovf2", 16'(ovf), 16'd0);
    @(negedge clk);
    chk("b2b.idle", 16'(busy | valid), 16'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
